// File: rtl/mux4_rr_arbiter_if.sv
// Bundle between the round-robin arbiter and the four requesters / shared resource.
//   req     requester -> arbiter  per-requester request lines
//   done    resource  -> arbiter  transaction finished (used only while granted)
//   gnt     arbiter   -> requesters one-hot grant, zero when idle
//   select  arbiter   -> mux      index of current/last owner
//   busy    arbiter   -> any      high while a grant is active
//   timeout arbiter   -> any      one-cycle pulse when the watchdog forced release
// master: arbiter side.  slave: requester/resource side.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] select;
  logic       busy;
  logic       timeout;

  modport master (
    input  req,
    input  done,
    output gnt,
    output select,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  gnt,
    input  select,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 muxed resource.
// A grant is held until the resource pulses done; a watchdog releases it after
// MAX_HOLD cycles so one requester cannot lock the resource.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    mux4_rr_arbiter_if.master (req/done in; gnt/select/busy/timeout out)
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mux4_rr_arbiter_if.master     bus
);

  typedef enum logic {StIdle, StGrant} state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       select_q, select_d;
  logic [1:0]       last_q, last_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic             found;
  logic [1:0]       winner;
  logic [1:0]       idx;

  // Scan last+1, last+2, last+3, last; the 2-bit add wraps 3->0.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    idx    = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    select_d   = select_q;
    last_d     = last_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StGrant;
          gnt_d      = 4'b0001 << winner;
          select_d   = winner;
          hold_cnt_d = '0;
        end
      end
      StGrant: begin
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
        // done has priority over the watchdog: no timeout pulse if both coincide.
        if (bus.done) begin
          state_d = StIdle;
          gnt_d   = 4'b0000;
          last_d  = select_q;
        end else if (hold_cnt_q == HoldLast) begin
          state_d   = StIdle;
          gnt_d     = 4'b0000;
          last_d    = select_q;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_q      <= 4'b0000;
      select_q   <= 2'b00;
      last_q     <= 2'b11;  // requester 0 wins first after reset
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      select_q   <= select_d;
      last_q     <= last_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.select  = select_q;
  assign bus.busy    = (state_q == StGrant);
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed stimulus, a transaction-level reference
// model checked every cycle, and hand-computed literal expectations.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 15;

  logic clk;
  logic reset;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: who owns the resource and for how many cycles so far.
  bit m_busy;
  int m_owner;
  int m_age;
  int m_last;
  bit m_to;

  // First requester after the previous owner, going round the ring.
  function automatic int pick(input logic [3:0] r, input int last);
    for (int d = 1; d <= 4; d++) begin
      int i;
      i = (last + d) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    m_busy  = 1'b0;
    m_owner = 0;
    m_age   = 0;
    m_last  = 3;
    m_to    = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_busy = 1'b0; m_owner = 0; m_age = 0; m_last = 3; m_to = 1'b0;
      end else if (!m_busy) begin
        m_to = 1'b0;
        if (bus.req != 4'b0000) begin
          m_owner = pick(bus.req, m_last);
          m_busy  = 1'b1;
          m_age   = 1;
        end
      end else if (bus.done) begin
        m_busy = 1'b0; m_last = m_owner; m_to = 1'b0;
      end else if (m_age == MAX_HOLD) begin
        m_busy = 1'b0; m_last = m_owner; m_to = 1'b1;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  // Literal expectation handed from the stimulus to the compare process.
  bit         lit_valid = 1'b0;
  string      lit_name;
  logic [3:0] lit_gnt;
  logic [1:0] lit_sel;
  logic       lit_busy;
  logic       lit_to;

  // Single compare process: model every cycle, plus any pending literal check.
  initial begin
    logic [3:0] e_gnt;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        tests = tests + 1;
        if (bus.gnt !== e_gnt || bus.select !== 2'(m_owner) || bus.busy !== m_busy ||
            bus.timeout !== m_to) begin
          fails = fails + 1;
          $display("FAIL model @%0t: gnt=%b sel=%0d busy=%b to=%b, want gnt=%b sel=%0d busy=%b to=%b",
                   $time, bus.gnt, bus.select, bus.busy, bus.timeout,
                   e_gnt, m_owner, m_busy, m_to);
        end
      end
      if (lit_valid) begin
        tests = tests + 1;
        if (bus.gnt !== lit_gnt || bus.select !== lit_sel || bus.busy !== lit_busy ||
            bus.timeout !== lit_to) begin
          fails = fails + 1;
          $display("FAIL %s @%0t: gnt=%b sel=%0d busy=%b to=%b, want gnt=%b sel=%0d busy=%b to=%b",
                   lit_name, $time, bus.gnt, bus.select, bus.busy, bus.timeout,
                   lit_gnt, lit_sel, lit_busy, lit_to);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] s,
                            input logic b, input logic t);
    lit_name  = name;
    lit_gnt   = g;
    lit_sel   = s;
    lit_busy  = b;
    lit_to    = t;
    lit_valid = 1'b1;
    @(negedge clk);
    #1;
    lit_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] rr [5];
    rr[0] = 2'd0; rr[1] = 2'd1; rr[2] = 2'd2; rr[3] = 2'd3; rr[4] = 2'd0;

    reset    = 1'b1;
    bus.req  = 4'b1111;
    bus.done = 1'b0;

    // T1: reset held two cycles with all requests up
    tick(); chk_en = 1'b1;
    expect_out("t1_rst0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("t1_rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    expect_out("t1_first", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.done = 1'b1; bus.req = 4'b0000;
    tick();
    expect_out("t1_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.done = 1'b0;

    // T2: single requester, request dropped, done three cycles in
    bus.req = 4'b0100;
    tick();
    expect_out("t2_g1", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    expect_out("t2_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    expect_out("t2_g3", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    expect_out("t2_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    bus.done = 1'b0;

    // T3: fresh reset, then all four requesting -> 0,1,2,3,0 with bubbles
    reset = 1'b1;
    tick();
    expect_out("t3_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0; bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      expect_out($sformatf("t3_grant%0d", g), 4'b0001 << rr[g], rr[g], 1'b1, 1'b0);
      tick();
      bus.done = 1'b1;
      tick();
      expect_out($sformatf("t3_bubble%0d", g), 4'b0000, rr[g], 1'b0, 1'b0);
      bus.done = 1'b0;
      if (g == 4) bus.req = 4'b0000;
    end

    // T4: owner 3 then 0 and 3 pending -> pointer wraps to 0
    bus.req = 4'b1000;
    tick();
    expect_out("t4_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    bus.done = 1'b1; bus.req = 4'b1001;
    tick();
    expect_out("t4_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
    bus.done = 1'b0;
    tick();
    expect_out("t4_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.done = 1'b1; bus.req = 4'b0000;
    tick();
    bus.done = 1'b0;

    // T5: watchdog on requester 1, requester 3 waiting
    bus.req = 4'b0010;
    tick();
    expect_out("t5_hold1", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.req = 4'b1010;
    for (int k = 2; k <= MAX_HOLD; k++) begin
      tick();
      expect_out($sformatf("t5_hold%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    expect_out("t5_timeout", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    expect_out("t5_next", 4'b1000, 2'd3, 1'b1, 1'b0);
    bus.req = 4'b0000;

    // T6a: done on the last allowed cycle -> no timeout pulse
    for (int k = 2; k <= MAX_HOLD; k++) begin
      tick();
      if (k == MAX_HOLD) bus.done = 1'b1;
    end
    tick();
    expect_out("t6_done_wins", 4'b0000, 2'd3, 1'b0, 1'b0);
    bus.done = 1'b0;
    tick();
    expect_out("t6_no_late_to", 4'b0000, 2'd3, 1'b0, 1'b0);

    // T6b: reset mid-grant -> arbitration restarts at requester 0
    bus.req = 4'b0100;
    tick();
    expect_out("t6_pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    reset = 1'b1; bus.req = 4'b1111;
    tick();
    expect_out("t6_rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    expect_out("t6_restart0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // T6c: owner drops its request, others stay up -> grant held until done
    bus.req = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("t6_held%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    bus.done = 1'b1; bus.req = 4'b0000;
    tick();
    expect_out("t6_drop_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.done = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
